simd_mem_req_arbiter: RTL and testbench
=======================================

SIMD_MEM_REQ_ARBITER -- requirements
Module: simd_mem_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the request splitter.
REQ-002 Parameter ADDR_WIDTH, default 64, byte-address width.
REQ-003 Parameter REQ_SIZE_WIDTH, default 16, request size width in bytes.
REQ-004 Parameter MAX_OUTSTANDING, default 8, limit on in-flight AXI sub-requests; minimum value 2.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester request pending.
REQ-008 req_addr  input  NUM_REQ*ADDR_WIDTH  flattened start addresses; requester i uses slice i.
REQ-009 req_size  input  NUM_REQ*REQ_SIZE_WIDTH  flattened byte sizes; requester i uses slice i.
REQ-010 req_ready  output  NUM_REQ  one-hot acceptance pulse.
REQ-011 split_addr  output  ADDR_WIDTH  address to the splitter.
REQ-012 split_addr_valid  output  1  one-cycle request strobe to the splitter.
REQ-013 split_req_size  output  REQ_SIZE_WIDTH  size to the splitter.
REQ-014 split_sm_complete  input  1  splitter idle or done.
REQ-015 split_out_valid  input  1  splitter emitted one AXI sub-request this cycle.
REQ-016 resp_done  input  1  one AXI sub-request retired this cycle.
REQ-017 grant_id  output  $clog2(NUM_REQ)  requester currently owning the splitter.
REQ-018 outstanding  output  $clog2(MAX_OUTSTANDING+1)  in-flight sub-request count.
REQ-019 busy  output  1  high in every state except ARB_IDLE.

Function
REQ-020 The FSM states SHALL be ARB_IDLE, ARB_ISSUE and ARB_WAIT.
REQ-021 ARB_IDLE: if any req_valid and outstanding <= MAX_OUTSTANDING-2 and split_sm_complete, the block SHALL grant one requester, pulse its req_ready, latch its addr/size and grant_id, and go to ARB_ISSUE.
REQ-022 Grant selection SHALL be round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap-around; last_grant updates only on a grant.
REQ-023 ARB_ISSUE: split_addr_valid SHALL be 1 for exactly this cycle with the latched addr/size; next state ARB_WAIT.
REQ-024 ARB_WAIT: the block SHALL return to ARB_IDLE on the first cycle split_sm_complete=1; the earliest return is 2 cycles after ARB_ISSUE.
REQ-025 Grant-to-strobe latency SHALL be 1 cycle; back-to-back throughput is one request per 4 cycles for an unsplit request.
REQ-026 split_addr and split_req_size SHALL hold the latched values from grant until the next grant.
REQ-027 outstanding SHALL increment on split_out_valid, decrement on resp_done, and hold when both occur in the same cycle.
REQ-028 resp_done at outstanding=0 SHALL be ignored (no underflow).
REQ-029 The threshold MAX_OUTSTANDING-2 SHALL guarantee room for a worst-case 2-way split, so outstanding never exceeds MAX_OUTSTANDING.
REQ-030 A requester deasserting req_valid before its grant SHALL NOT be granted; req_valid is not sampled after the grant.

Reset
REQ-031 Under reset: state=ARB_IDLE, req_ready=0, split_addr_valid=0, split_addr=0, split_req_size=0, grant_id=0, outstanding=0, busy=0, and last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no strobe emitted in the reset cycle.

Structure
REQ-033 The state enum and the ARB_* encodings SHALL reside in shared package simd_mem_arb_pkg.
REQ-034 Round-robin selection SHALL be a sub-module, rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any_grant).

Verification
REQ-035 Single request: req_valid[2]=1, addr 0x1000, size 256 -> req_ready[2] pulse, strobe next cycle with 0x1000/256, grant_id=2, busy low again after the splitter completes.
REQ-036 All four requesters valid continuously -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
REQ-037 Split request: addr 0x0FC0, size 128; splitter emits two split_out_valid -> outstanding reaches 2; two resp_done -> outstanding returns to 0.
REQ-038 MAX_OUTSTANDING=8, outstanding=7 with req_valid[0]=1 -> no grant until one resp_done brings outstanding to 6, then grant.
REQ-039 split_out_valid and resp_done in the same cycle at outstanding=3 -> outstanding stays 3; resp_done at 0 -> stays 0.
REQ-040 Reset asserted in ARB_WAIT -> next cycle ARB_IDLE with all outputs at reset values; first grant afterwards goes to requester 0.

Source files
------------

// File: rtl/simd_mem_arb_pkg.sv
// Shared definitions for the SIMD memory request arbiter.
// Holds the arbiter FSM state encoding and a helper that sizes requester
// index fields so that a single-requester build still gets a 1-bit field.
package simd_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simd_mem_req_arbiter_rr_arbiter.sv
// Round-robin requester selection.
// Ports:
//   req_i        request vector, one bit per requester
//   last_grant_i index of the most recently granted requester
//   grant_o      one-hot winner (all zero when nothing requests)
//   grant_idx_o  binary index of the winner
//   any_grant_o  high when some requester won
// The search starts one past last_grant_i and wraps, so the previous
// winner has the lowest priority on the next decision.
module rr_arbiter
  import simd_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_grant_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    cand        = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant_i) + off) % NUM_REQ);
      if (!any_grant_o && req_i[cand]) begin
        any_grant_o       = 1'b1;
        grant_idx_o       = cand;
        grant_o[cand]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simd_mem_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared AXI request splitter.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   req_valid/addr/size per-requester request, addr/size flattened by index
//   req_ready           one-hot acceptance pulse in the grant cycle
//   split_addr(_valid)  latched address and one-cycle strobe to the splitter
//   split_req_size      latched size to the splitter
//   split_sm_complete   splitter idle/done
//   split_out_valid     splitter emitted one AXI sub-request
//   resp_done           one AXI sub-request retired
//   grant_id            requester currently owning the splitter
//   outstanding         in-flight sub-request count
//   busy                arbiter not idle
// Flow: IDLE (grant) -> ISSUE (strobe) -> WAIT (until splitter complete).
module simd_mem_req_arbiter
  import simd_mem_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int ADDR_WIDTH      = 64,
  parameter  int REQ_SIZE_WIDTH  = 16,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int IDX_W           = idx_width(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*REQ_SIZE_WIDTH-1:0] req_size,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [ADDR_WIDTH-1:0]             split_addr,
  output logic                              split_addr_valid,
  output logic [REQ_SIZE_WIDTH-1:0]         split_req_size,
  input  logic                              split_sm_complete,
  input  logic                              split_out_valid,
  input  logic                              resp_done,
  output logic [IDX_W-1:0]                  grant_id,
  output logic [CNT_W-1:0]                  outstanding,
  output logic                              busy
);

  // A new grant needs room for a worst-case two-way split.
  localparam logic [CNT_W-1:0] GRANT_LIMIT = CNT_W'(MAX_OUTSTANDING - 2);

  arb_state_e                state_q;
  logic [IDX_W-1:0]          last_grant_q;
  logic [IDX_W-1:0]          grant_id_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [REQ_SIZE_WIDTH-1:0] size_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;

  logic [NUM_REQ-1:0]        gnt_onehot;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      gnt_any;
  logic                      grant_fire;
  logic                      dec_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (gnt_onehot),
    .grant_idx_o  (gnt_idx),
    .any_grant_o  (gnt_any)
  );

  // Reset gates the grant so nothing is accepted in a reset cycle.
  assign grant_fire = !reset && (state_q == ARB_IDLE) && gnt_any &&
                      (cnt_q <= GRANT_LIMIT) && split_sm_complete;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      addr_q       <= '0;
      size_q       <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_fire) begin
            state_q      <= ARB_ISSUE;
            last_grant_q <= gnt_idx;
            grant_id_q   <= gnt_idx;
            addr_q       <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            size_q       <= req_size[int'(gnt_idx)*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
          end
        end
        ARB_ISSUE: state_q <= ARB_WAIT;
        ARB_WAIT:  if (split_sm_complete) state_q <= ARB_IDLE;
        default:   state_q <= ARB_IDLE;
      endcase
    end
  end

  // A retirement with nothing in flight is spurious and dropped; a
  // simultaneous emit and retire cancel out.
  assign dec_ok = resp_done && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (split_out_valid && !dec_ok) cnt_d = cnt_q + CNT_W'(1);
    else if (!split_out_valid && dec_ok) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign req_ready        = grant_fire ? gnt_onehot : '0;
  assign split_addr_valid = (state_q == ARB_ISSUE) && !reset;
  assign busy             = (state_q != ARB_IDLE) && !reset;
  assign split_addr       = addr_q;
  assign split_req_size   = size_q;
  assign grant_id         = grant_id_q;
  assign outstanding      = cnt_q;

endmodule

// File: tb/tb_simd_mem_req_arbiter.sv
module tb_simd_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int SW = 16;
  localparam int MO = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*SW-1:0] req_size;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   split_addr;
  logic            split_addr_valid;
  logic [SW-1:0]   split_req_size;
  logic            split_sm_complete;
  logic            split_out_valid;
  logic            resp_done;
  logic [IW-1:0]   grant_id;
  logic [CW-1:0]   outstanding;
  logic            busy;

  simd_mem_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .REQ_SIZE_WIDTH(SW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_ready(req_ready), .split_addr(split_addr),
    .split_addr_valid(split_addr_valid), .split_req_size(split_req_size),
    .split_sm_complete(split_sm_complete), .split_out_valid(split_out_valid),
    .resp_done(resp_done), .grant_id(grant_id), .outstanding(outstanding),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    int            id;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   glog[$];
  int   rr_exp[5] = '{0, 1, 2, 3, 0};

  // requester side
  logic          pend_v[N];
  logic [AW-1:0] pend_a[N];
  logic [SW-1:0] pend_s[N];
  bit            rst_drv;
  bit            refill;
  int            sov_mode = -1;
  int            rd_mode  = -1;
  int            cmpl_mode = -1;

  // reference model: arbiter availability, owner, latched request, count
  int            m_cnt, m_last, m_age, m_id;
  bit            m_free;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;

  // splitter stand-in
  bit spl_busy;
  int spl_todo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // A request crossing a 4 KB boundary splits into two sub-requests.
  function automatic int pieces(input logic [AW-1:0] a, input logic [SW-1:0] s);
    return ((int'(a[11:0]) + int'(s)) > 4096) ? 2 : 1;
  endfunction

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < N; i++) if (pend_v[i]) r = 1;
    return r;
  endfunction

  task automatic new_req(input int i, input logic [AW-1:0] a, input logic [SW-1:0] s);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_s[i] = s;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_free = 1; m_age = 0; m_last = N - 1; m_id = 0;
    m_addr = '0; m_size = '0;
    spl_busy = 0; spl_todo = 0;
    exp_q.delete();
  endtask

  task automatic step();
    bit           sov, rd, cmpl;
    int           win;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    sov = 0; cmpl = 1;
    if (spl_busy) begin
      cmpl = 0;
      if (spl_todo > 0) begin
        if ($urandom_range(0, 3) != 0) begin sov = 1; spl_todo--; end
      end else begin
        cmpl = 1; spl_busy = 0;
      end
    end
    if (sov_mode >= 0)  sov  = (sov_mode == 1);
    if (cmpl_mode >= 0) cmpl = (cmpl_mode == 1);
    rd = (rd_mode >= 0) ? (rd_mode == 1) : (m_cnt > 0 && $urandom_range(0, 2) == 0);
    reset = rst_drv; split_out_valid = sov; resp_done = rd; split_sm_complete = cmpl;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend_v[i];
      req_addr[i*AW +: AW] = pend_a[i];
      req_size[i*SW +: SW] = pend_s[i];
    end
    #1;
    win = -1;
    if (!rst_drv && m_free && cmpl && m_cnt <= MO - 2)
      for (int k = 1; k <= N; k++)
        if (win < 0 && pend_v[(m_last + k) % N]) win = (m_last + k) % N;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, !rst_drv && !m_free);
    chk("strobe", split_addr_valid, !rst_drv && !m_free && m_age == 1);
    chk("outstanding", outstanding, m_cnt);
    chk("split_addr_hold", split_addr, m_addr);
    chk("split_size_hold", split_req_size, m_size);
    chk("grant_id_hold", grant_id, m_id);
    if (!rst_drv && !m_free && m_age == 1) begin
      spl_busy = 1;
      spl_todo = pieces(m_addr, m_size);
    end
    if (rst_drv) model_reset();
    else begin
      if (sov && !(rd && m_cnt > 0)) m_cnt++;
      else if (!sov && rd && m_cnt > 0) m_cnt--;
      if (!m_free) begin
        if (m_age >= 2 && cmpl) m_free = 1;
        else m_age++;
      end else if (win >= 0) begin
        m_free = 0; m_age = 1; m_last = win; m_id = win;
        m_addr = pend_a[win]; m_size = pend_s[win];
        exp_q.push_back('{pend_a[win], pend_s[win], win});
        glog.push_back(win);
        pend_v[win] = 1'b0;
        if (refill) new_req(win, AW'({$urandom, $urandom}), SW'(64));
      end
    end
  endtask

  task automatic run_idle(input int limit);
    int n = 0;
    while ((!m_free || spl_busy || any_pend()) && n < limit) begin step(); n++; end
    if (n >= limit) timeout_fail("idle_timeout");
  endtask

  task automatic drain();
    int n = 0;
    rd_mode = 1;
    while (m_cnt > 0 && n < 50) begin step(); n++; end
    rd_mode = 0;
    step();
    rd_mode = -1;
    if (n >= 50) timeout_fail("drain_timeout");
  endtask

  // Strobe monitor: each splitter strobe must match the oldest grant.
  always @(posedge clk) begin
    #1;
    if (split_addr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: addr 0x%0h with no grant pending at %0t", split_addr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_addr", split_addr, mon_e.addr);
        chk("strobe_size", split_req_size, mon_e.size);
        chk("strobe_grant_id", grant_id, mon_e.id);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_size = '0;
    split_sm_complete = 1'b1; split_out_valid = 1'b0; resp_done = 1'b0;
    for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_a[i] = '0; pend_s[i] = '0; end
    refill = 0; rst_drv = 1;
    model_reset();
    repeat (3) step();
    rst_drv = 0;
    step();

    // single request on requester 2
    glog.delete(); rd_mode = 0;
    new_req(2, AW'(64'h1000), SW'(256));
    run_idle(50);
    chk("single_grant", (glog.size() > 0) ? glog[0] : -1, 2);
    drain();

    // all four continuously valid after reset: 0,1,2,3,0
    rst_drv = 1; step(); rst_drv = 0;
    glog.delete(); refill = 1;
    for (int i = 0; i < N; i++) new_req(i, AW'(64'h4000 + i * 256), SW'(64));
    n = 0;
    while (glog.size() < 5 && n < 100) begin step(); n++; end
    refill = 0;
    for (int k = 0; k < 5; k++) chk("rr_order", (k < glog.size()) ? glog[k] : -1, rr_exp[k]);
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    run_idle(100);
    drain();

    // 4 KB-crossing request splits in two
    rd_mode = 0;
    new_req(1, AW'(64'h0FC0), SW'(128));
    run_idle(50);
    chk("split_outstanding", outstanding, 2);
    rd_mode = 1; step(); step(); rd_mode = 0; step();
    chk("split_drained", outstanding, 0);

    // outstanding at 7 blocks the grant until it drops to 6
    sov_mode = 1; repeat (7) step(); sov_mode = -1;
    glog.delete();
    new_req(0, AW'(64'h2000), SW'(64));
    repeat (3) step();
    chk("limit_blocks", glog.size(), 0);
    rd_mode = 1; step(); rd_mode = 0; step();
    chk("limit_grant", (glog.size() == 1) ? glog[0] : -1, 0);
    run_idle(50);
    chk("limit_peak", outstanding, 7);
    drain();

    // simultaneous emit/retire holds; retire at zero is ignored
    sov_mode = 1; rd_mode = 0; repeat (3) step();
    rd_mode = 1; step();
    sov_mode = 0; rd_mode = 0; step();
    chk("both_hold", outstanding, 3);
    rd_mode = 1; repeat (5) step();
    rd_mode = 0; step();
    chk("underflow_guard", outstanding, 0);
    sov_mode = -1; rd_mode = -1;

    // requester withdrawing before its grant is never granted
    sov_mode = 1; rd_mode = 0; repeat (7) step(); sov_mode = -1;
    glog.delete();
    new_req(3, AW'(64'h5000), SW'(32));
    repeat (2) step();
    pend_v[3] = 0;
    drain();
    run_idle(20);
    chk("withdrawn_not_granted", glog.size(), 0);

    // reset while waiting on the splitter
    glog.delete();
    new_req(1, AW'(64'h3000), SW'(32));
    n = 0;
    while (!(!m_free && m_age >= 2) && n < 20) begin step(); n++; end
    if (n >= 20) timeout_fail("reach_wait");
    cmpl_mode = 0; repeat (2) step();
    rst_drv = 1; step(); rst_drv = 0; cmpl_mode = -1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_addr", split_addr, 0);
    chk("rst_size", split_req_size, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_outstanding", outstanding, 0);
    glog.delete();
    for (int i = 0; i < N; i++) new_req(i, AW'(64'h6000 + i * 64), SW'(64));
    run_idle(200);
    chk("post_reset_first", (glog.size() > 0) ? glog[0] : -1, 0);
    drain();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 5) == 0)
          new_req(i, AW'({$urandom, $urandom}), SW'($urandom_range(1, 4096)));
        else if (pend_v[i] && $urandom_range(0, 60) == 0)
          pend_v[i] = 0;
      end
      step();
    end
    run_idle(500);
    drain();
    step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
